multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max consecutive wait cycles (mem_ready low) per memory access before fault.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 OpCode  input  11  instruction bits [31:21] from instruction register, valid from DECODE onward.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, Reg2Loc, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 Aluop  output  2  00 add, 01 pass-B/zero test, 10 R-type function.
REQ-010 PCSource  output  2  00 ALU result, 01 ALUOut, 10 branch target.
REQ-011 fault  output  1  sticky error flag; state  output  4  current state encoding (debug).

Function
REQ-012 States SHALL be FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, CBZ_EX, B_EX, FAULT.
REQ-013 FETCH: MemRead=1, IorD=0; when mem_ready=1 same cycle IRWrite=1, ALUSrcA=0, ALUSrcB=01, Aluop=00, PCSource=00, PCWrite=1, next DECODE; else stay.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, Aluop=00 (branch target to ALUOut); class OpCode and branch: R-type 1xx0101x000 -> R_EXEC; LDUR 11111000010 or STUR 11111000000 -> MEM_ADDR; CBZ 10110100xxx -> CBZ_EX; B 000101xxxxx -> B_EX; any other -> FAULT.
REQ-015 Reg2Loc SHALL be 1 from DECODE through instruction end for STUR and CBZ, else 0.
REQ-016 R_EXEC: ALUSrcA=1, ALUSrcB=00, Aluop=10 -> R_WB; R_WB: RegWrite=1, MemtoReg=0 -> FETCH.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, Aluop=00 -> MEM_RD (LDUR) or MEM_WR (STUR).
REQ-018 MEM_RD: IorD=1, MemRead=1 held until mem_ready -> MEM_WB; MEM_WB: RegWrite=1, MemtoReg=1 -> FETCH.
REQ-019 MEM_WR: IorD=1, MemWrite=1 held until mem_ready -> FETCH.
REQ-020 CBZ_EX: ALUSrcA=1, ALUSrcB=00, Aluop=01, PCWriteCond=1, PCSource=01 -> FETCH; PC updates only if Zero=1 (datapath ANDs PCWriteCond with Zero).
REQ-021 B_EX: PCWrite=1, PCSource=10 -> FETCH.
REQ-022 Minimum latency (mem_ready always high): R 4, LDUR 5, STUR 4, CBZ 3, B 3 cycles.
REQ-023 Wait counter: clears on entering FETCH/MEM_RD/MEM_WR and on mem_ready=1; increments each wait cycle with mem_ready low; on reaching MEM_TIMEOUT with mem_ready still low -> FAULT; mem_ready=1 on the boundary cycle SHALL win (access completes).
REQ-024 FAULT: all strobes 0, fault=1, stays until reset.
REQ-025 Outputs not listed for a state SHALL be 0; all outputs combinational from state (plus mem_ready in FETCH), no glitch-sensitive paths.
REQ-026 MemRead and MemWrite SHALL never be high together.

Reset
REQ-027 reset high at an edge SHALL set state=FETCH, counter=0, fault=0, from any state including mid-access or FAULT.
REQ-028 While reset is high all outputs SHALL be driven 0; first cycle after deassertion presents FETCH outputs (MemRead=1).

Structure
REQ-029 Shared package legv8_pkg SHALL hold opcode patterns, state enum, ALUSrcB/Aluop/PCSource encodings.
REQ-030 One sub-module opclass_decode (combinational OpCode -> class {RTYPE, LDUR, STUR, CBZ, B, ILLEGAL}) SHALL be instantiated.

Verification
REQ-031 Reset, then ADD 10001011000 with mem_ready=1 -> states FETCH,DECODE,R_EXEC,R_WB; RegWrite=1 only in cycle 4.
REQ-032 LDUR 11111000010, mem_ready low 3 cycles in MEM_RD -> MemRead, IorD held 3 cycles; MEM_WB RegWrite=1, MemtoReg=1; total 8 cycles.
REQ-033 CBZ 10110100101 with Zero=1 then Zero=0 -> PCWriteCond=1, PCSource=01, Reg2Loc=1 in CBZ_EX both times; back to FETCH after 3 cycles.
REQ-034 OpCode 00000000000 -> FAULT after DECODE, fault=1 held 20 cycles; reset -> FETCH, fault=0.
REQ-035 mem_ready held low in FETCH -> FAULT after 15 wait cycles; repeat with mem_ready=1 on 15th wait cycle -> DECODE, no fault.
REQ-036 reset asserted during MEM_WR wait -> next cycle FETCH, MemWrite=0, counter=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg
// Shared definitions for the LEGv8 multicycle controller:
//   - instruction class enum produced by opclass_decode
//   - opcode mask/match patterns for OpCode = instruction[31:21]
//   - controller state encodings (also visible on the debug state port)
//   - ALUSrcB / Aluop / PCSource select encodings
package legv8_pkg;

    typedef enum logic [2:0] {
        OPC_RTYPE   = 3'd0,
        OPC_LDUR    = 3'd1,
        OPC_STUR    = 3'd2,
        OPC_CBZ     = 3'd3,
        OPC_B       = 3'd4,
        OPC_ILLEGAL = 3'd5
    } opClassE;

    // R-type is 1xx0101x000; x bits are cleared in the mask.
    localparam logic [10:0] RTYPE_MASK  = 11'b10011110111;
    localparam logic [10:0] RTYPE_MATCH = 11'b10001010000;
    localparam logic [10:0] LDUR_OP     = 11'b11111000010;
    localparam logic [10:0] STUR_OP     = 11'b11111000000;
    // CBZ is 10110100xxx
    localparam logic [10:0] CBZ_MASK    = 11'b11111111000;
    localparam logic [10:0] CBZ_MATCH   = 11'b10110100000;
    // B is 000101xxxxx
    localparam logic [10:0] B_MASK      = 11'b11111100000;
    localparam logic [10:0] B_MATCH     = 11'b00010100000;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_R_EXEC   = 4'd2;
    localparam logic [3:0] S_R_WB     = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WB   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_CBZ_EX   = 4'd8;
    localparam logic [3:0] S_B_EX     = 4'd9;
    localparam logic [3:0] S_FAULT    = 4'd10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;

    function automatic logic opMatch(input logic [10:0] op,
                                     input logic [10:0] mask,
                                     input logic [10:0] match);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/opclass_decode.sv
// opclass_decode
// Purely combinational classification of the instruction opcode field.
// Ports:
//   OpCode  in  11  instruction bits [31:21]
//   opClass out     instruction class (RTYPE/LDUR/STUR/CBZ/B/ILLEGAL)
module opclass_decode
    import legv8_pkg::*;
(
    input  logic [10:0] OpCode,
    output opClassE     opClass
);

    always_comb begin
        if (opMatch(OpCode, RTYPE_MASK, RTYPE_MATCH)) begin
            opClass = OPC_RTYPE;
        end else if (OpCode == LDUR_OP) begin
            opClass = OPC_LDUR;
        end else if (OpCode == STUR_OP) begin
            opClass = OPC_STUR;
        end else if (opMatch(OpCode, CBZ_MASK, CBZ_MATCH)) begin
            opClass = OPC_CBZ;
        end else if (opMatch(OpCode, B_MASK, B_MATCH)) begin
            opClass = OPC_B;
        end else begin
            opClass = OPC_ILLEGAL;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle LEGv8 control FSM with memory-handshake timeout.
// Ports:
//   clk, reset (sync, active-high)
//   OpCode[10:0]  instruction bits [31:21], valid from DECODE onward
//   Zero          ALU zero flag (consumed by the datapath PC-write gate)
//   mem_ready     memory access completes in the cycle it is high
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   Reg2Loc, RegWrite, ALUSrcA        datapath strobes/selects
//   ALUSrcB[1:0], Aluop[1:0], PCSource[1:0]   datapath selects
//   fault         sticky error flag (held until reset)
//   state[3:0]    current state encoding for debug
//
// state      | meaning
// -----------+-----------------------------------------------------
// FETCH      | read instruction, PC+4 when mem_ready
// DECODE     | classify opcode, branch target into ALUOut
// R_EXEC     | R-type ALU operation
// R_WB       | R-type register write-back
// MEM_ADDR   | load/store effective address
// MEM_RD     | data read, waits for mem_ready
// MEM_WB     | load register write-back
// MEM_WR     | data write, waits for mem_ready
// CBZ_EX     | zero test, conditional PC update from ALUOut
// B_EX       | unconditional branch
// FAULT      | illegal opcode or memory timeout, held until reset
module multicycle_control
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] OpCode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  Aluop,
    output logic [1:0]  PCSource,
    output logic        fault,
    output logic [3:0]  state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [3:0]    stateQ;
    logic [3:0]    nextState;
    logic [CW-1:0] waitCnt;
    logic          storeQ;
    logic          inWait;
    logic          timeoutHit;
    opClassE       opClass;

    // Zero only qualifies PCWriteCond inside the datapath; the controller
    // never branches on it.
    logic unusedZero;
    assign unusedZero = Zero;

    opclass_decode opDecode (
        .OpCode  (OpCode),
        .opClass (opClass)
    );

    assign inWait = (stateQ == S_FETCH) || (stateQ == S_MEM_RD) ||
                    (stateQ == S_MEM_WR);

    // Asserted on the MEM_TIMEOUT-th consecutive low cycle of one access;
    // a high mem_ready in that same cycle is checked first and wins.
    assign timeoutHit = (waitCnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        nextState = stateQ;
        case (stateQ)
            S_FETCH: begin
                if (mem_ready)       nextState = S_DECODE;
                else if (timeoutHit) nextState = S_FAULT;
            end
            S_DECODE: begin
                case (opClass)
                    OPC_RTYPE: nextState = S_R_EXEC;
                    OPC_LDUR:  nextState = S_MEM_ADDR;
                    OPC_STUR:  nextState = S_MEM_ADDR;
                    OPC_CBZ:   nextState = S_CBZ_EX;
                    OPC_B:     nextState = S_B_EX;
                    default:   nextState = S_FAULT;
                endcase
            end
            S_R_EXEC:   nextState = S_R_WB;
            S_R_WB:     nextState = S_FETCH;
            S_MEM_ADDR: nextState = storeQ ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)       nextState = S_MEM_WB;
                else if (timeoutHit) nextState = S_FAULT;
            end
            S_MEM_WB:   nextState = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)       nextState = S_FETCH;
                else if (timeoutHit) nextState = S_FAULT;
            end
            S_CBZ_EX:   nextState = S_FETCH;
            S_B_EX:     nextState = S_FETCH;
            S_FAULT:    nextState = S_FAULT;
            default:    nextState = S_FAULT;
        endcase
    end

    // The counter is zero in every non-wait state, so it is already clear
    // whenever FETCH, MEM_RD or MEM_WR is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= S_FETCH;
            waitCnt <= '0;
            storeQ  <= 1'b0;
        end else begin
            stateQ <= nextState;
            if (inWait && !mem_ready) waitCnt <= waitCnt + 1'b1;
            else                      waitCnt <= '0;
            // Remember load vs store so MEM_ADDR does not depend on OpCode.
            if (stateQ == S_DECODE) storeQ <= (opClass == OPC_STUR);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        Reg2Loc     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        Aluop       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        fault       = 1'b0;
        state       = '0;
        if (!reset) begin
            state = stateQ;
            case (stateQ)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite  = 1'b1;
                        ALUSrcB  = SRCB_FOUR;
                        Aluop    = ALUOP_ADD;
                        PCSource = PCSRC_ALU;
                        PCWrite  = 1'b1;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH2;
                    Reg2Loc = (opClass == OPC_STUR) || (opClass == OPC_CBZ);
                end
                S_R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    Aluop   = ALUOP_RTYPE;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    Reg2Loc = storeQ;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                S_CBZ_EX: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REG;
                    Aluop       = ALUOP_PASSB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    Reg2Loc     = 1'b1;
                end
                S_B_EX: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_BRANCH;
                end
                S_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    fault = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus side walks each
// instruction through its expected state sequence and queues the expected
// control word per cycle; the monitor pops and compares on the falling edge.
module tb_multicycle_control;
    import legv8_pkg::*;

    localparam int MEM_TIMEOUT = 15;
    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] OpCode;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, Reg2Loc, RegWrite, ALUSrcA, fault;
    logic [1:0]  ALUSrcB, Aluop, PCSource;
    logic [3:0]  state;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .Aluop(Aluop), .PCSource(PCSource), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, r2l, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic flt;
    } ctlT;

    typedef struct {
        ctlT ctl;
        int  tag;
    } expT;

    expT  expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   instrNo = 0;
    logic zeroVal = 1'b0;

    function automatic int classify(input logic [10:0] op);
        int c;
        casez (op)
            11'b1??0101?000: c = C_R;
            11'b11111000010: c = C_LD;
            11'b11111000000: c = C_ST;
            11'b10110100???: c = C_CBZ;
            11'b000101?????: c = C_B;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    // Control word the datapath should see in a given state.
    function automatic ctlT expOut(input logic [3:0] st, input logic rdy, input int cls);
        ctlT e;
        e = '0;
        e.st = st;
        e.r2l = (st != S_FETCH) && (st != S_FAULT) && (cls == C_ST || cls == C_CBZ);
        case (st)
            S_FETCH: begin
                e.mrd = 1'b1;
                if (rdy) begin e.irw = 1'b1; e.asb = 2'b01; e.pcw = 1'b1; end
            end
            S_DECODE:   e.asb = 2'b11;
            S_R_EXEC:   begin e.asa = 1'b1; e.aop = 2'b10; end
            S_R_WB:     e.rw = 1'b1;
            S_MEM_ADDR: begin e.asa = 1'b1; e.asb = 2'b10; end
            S_MEM_RD:   begin e.iord = 1'b1; e.mrd = 1'b1; end
            S_MEM_WB:   begin e.rw = 1'b1; e.m2r = 1'b1; end
            S_MEM_WR:   begin e.iord = 1'b1; e.mwr = 1'b1; end
            S_CBZ_EX:   begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; end
            S_B_EX:     begin e.pcw = 1'b1; e.pcs = 2'b10; end
            S_FAULT:    e.flt = 1'b1;
            default:    ;
        endcase
        return e;
    endfunction

    task automatic drive(input ctlT e);
        expT x;
        x.ctl = e;
        x.tag = instrNo;
        expQ.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic other(input logic [3:0] st, input int cls);
        mem_ready = 1'($urandom);
        Zero = zeroVal;
        drive(expOut(st, 1'b0, cls));
    endtask

    // An access of 'waits' low cycles then one ready cycle; MEM_TIMEOUT or
    // more low cycles means the access faults instead.
    task automatic memPhase(input logic [3:0] st, input int waits, input int cls, output bit ok);
        for (int i = 0; i < waits && i < MEM_TIMEOUT; i++) begin
            mem_ready = 1'b0;
            Zero = zeroVal;
            drive(expOut(st, 1'b0, cls));
        end
        if (waits >= MEM_TIMEOUT) begin
            ok = 1'b0;
        end else begin
            mem_ready = 1'b1;
            Zero = zeroVal;
            drive(expOut(st, 1'b1, cls));
            ok = 1'b1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        mem_ready = 1'($urandom);
        OpCode = 11'($urandom);
        drive('0);
        reset = 1'b0;
    endtask

    task automatic faultHold(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            Zero = 1'($urandom);
            drive(expOut(S_FAULT, 1'b0, C_ILL));
        end
    endtask

    task automatic runInstr(input logic [10:0] op, input int fWait, input int mWait, output bit faulted);
        int cls;
        bit ok;
        cls = classify(op);
        faulted = 1'b0;
        instrNo++;
        OpCode = 11'($urandom);
        memPhase(S_FETCH, fWait, cls, ok);
        if (!ok) begin faulted = 1'b1; return; end
        OpCode = op;
        other(S_DECODE, cls);
        case (cls)
            C_R: begin other(S_R_EXEC, cls); other(S_R_WB, cls); end
            C_LD: begin
                other(S_MEM_ADDR, cls);
                memPhase(S_MEM_RD, mWait, cls, ok);
                if (!ok) begin faulted = 1'b1; return; end
                other(S_MEM_WB, cls);
            end
            C_ST: begin
                other(S_MEM_ADDR, cls);
                memPhase(S_MEM_WR, mWait, cls, ok);
                if (!ok) begin faulted = 1'b1; return; end
            end
            C_CBZ: other(S_CBZ_EX, cls);
            C_B:   other(S_B_EX, cls);
            default: faulted = 1'b1;
        endcase
    endtask

    task automatic runAndRecover(input logic [10:0] op, input int fWait, input int mWait, input int hold);
        bit f;
        runInstr(op, fWait, mWait, f);
        if (f) begin
            faultHold(hold);
            doReset();
        end
    endtask

    function automatic int pickWait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 12) return r % 4;
        return r + 1;
    endfunction

    function automatic logic [10:0] randOp();
        logic [10:0] r;
        int k;
        r = 11'($urandom);
        k = int'($urandom_range(0, 5));
        case (k)
            0: return 11'b10001010000 | (r & 11'b01100001000);
            1: return 11'b11111000010;
            2: return 11'b11111000000;
            3: return 11'b10110100000 | (r & 11'b00000000111);
            4: return 11'b00010100000 | (r & 11'b00000011111);
            default: begin
                for (int i = 0; i < 20 && classify(r) != C_ILL; i++) r = 11'($urandom);
                if (classify(r) != C_ILL) r = 11'b00000000000;
                return r;
            end
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                expT x;
                ctlT got;
                x = expQ.pop_front();
                got.st = state;      got.pcw = PCWrite;   got.pcwc = PCWriteCond;
                got.iord = IorD;     got.mrd = MemRead;   got.mwr = MemWrite;
                got.irw = IRWrite;   got.m2r = MemtoReg;  got.r2l = Reg2Loc;
                got.rw = RegWrite;   got.asa = ALUSrcA;   got.asb = ALUSrcB;
                got.aop = Aluop;     got.pcs = PCSource;  got.flt = fault;
                checks++;
                if (got !== x.ctl) begin
                    errors++;
                    $display("FAIL ctl instr=%0d t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                             x.tag, $time, got.st, x.ctl.st, got, x.ctl);
                end
                checks++;
                if (MemRead && MemWrite) begin
                    errors++;
                    $display("FAIL memExclusive instr=%0d got MemRead=1 MemWrite=1 required not both", x.tag);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        Zero = 1'b0;
        OpCode = '0;
        @(posedge clk);
        #1;
        doReset();

        runAndRecover(11'b10001011000, 0, 0, 2);          // ADD, minimum latency
        runAndRecover(11'b11111000010, 0, 3, 2);          // LDUR, 3 waits in MEM_RD
        zeroVal = 1'b1;
        runAndRecover(11'b10110100101, 0, 0, 2);          // CBZ, Zero=1
        zeroVal = 1'b0;
        runAndRecover(11'b10110100101, 0, 0, 2);          // CBZ, Zero=0
        runAndRecover(11'b00010100011, 0, 0, 2);          // B
        runAndRecover(11'b11111000000, 0, 0, 2);          // STUR
        runAndRecover(11'b00000000000, 0, 0, 20);         // illegal, held 20 cycles
        runAndRecover(11'b10001011000, 15, 0, 3);         // FETCH timeout
        runAndRecover(11'b10001011000, 14, 0, 3);         // ready on boundary cycle
        runAndRecover(11'b11111000010, 1, 15, 3);         // MEM_RD timeout
        runAndRecover(11'b11111000000, 0, 14, 3);         // MEM_WR boundary

        // Reset in the middle of a MEM_WR wait, then a full-length fetch wait
        // that only survives if the wait counter was cleared.
        instrNo++;
        OpCode = 11'($urandom);
        mem_ready = 1'b1;
        drive(expOut(S_FETCH, 1'b1, C_ST));
        OpCode = 11'b11111000000;
        other(S_DECODE, C_ST);
        other(S_MEM_ADDR, C_ST);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'b0;
            drive(expOut(S_MEM_WR, 1'b0, C_ST));
        end
        doReset();
        runAndRecover(11'b10001011000, 14, 0, 3);

        for (int n = 0; n < 250; n++) begin
            zeroVal = 1'($urandom);
            runAndRecover(randOp(), pickWait(), pickWait(), int'($urandom_range(1, 4)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
